// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous square wave in fast-clock cycles.
// Define CLK_PERIOD_METER_AVG_EN to publish the mean of every 4 measurements instead.
module clk_period_meter #(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned TIMEOUT = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             timeout,
    output logic             busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             hist_q;
    logic             edge_det;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] period_q, period_d;
    logic             vld_q, vld_d;
    logic             timeout_q, timeout_d;
    logic             busy_q;

`ifdef CLK_PERIOD_METER_AVG_EN
    logic [CNT_W+1:0] acc_q, acc_d, acc_sum;
    logic [1:0]       samp_q, samp_d;
`endif

    assign edge_det = sync_q[1] & ~hist_q;
    // Counter saturates rather than wrapping.
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

`ifdef CLK_PERIOD_METER_AVG_EN
    assign acc_sum = acc_q + {2'b00, cnt_q};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        vld_d     = 1'b0;
        timeout_d = timeout_q;
`ifdef CLK_PERIOD_METER_AVG_EN
        acc_d     = acc_q;
        samp_d    = samp_q;
`endif
        if (!meas_en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
            acc_d     = '0;
            samp_d    = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (edge_det) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEASURE;
                    end else if (cnt_q >= TIMEOUT_VAL) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                MEASURE: begin
                    // An edge takes priority over an expiring count.
                    if (edge_det) begin
                        cnt_d = CNT_ONE;
`ifdef CLK_PERIOD_METER_AVG_EN
                        if (samp_q == 2'd3) begin
                            period_d  = acc_sum[CNT_W+1:2];
                            vld_d     = 1'b1;
                            timeout_d = 1'b0;
                            acc_d     = '0;
                            samp_d    = '0;
                        end else begin
                            acc_d  = acc_sum;
                            samp_d = samp_q + 2'd1;
                        end
`else
                        period_d  = cnt_q;
                        vld_d     = 1'b1;
                        timeout_d = 1'b0;
`endif
                    end else if (cnt_q >= TIMEOUT_VAL) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ARM;
`ifdef CLK_PERIOD_METER_AVG_EN
                        acc_d     = '0;
                        samp_d    = '0;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            vld_q     <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], sig_in};
            hist_q    <= sync_q[1];
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            vld_q     <= vld_d;
            timeout_q <= timeout_d;
            busy_q    <= (state_d != IDLE);
        end
    end

`ifdef CLK_PERIOD_METER_AVG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            samp_q <= '0;
        end else begin
            acc_q  <= acc_d;
            samp_q <= samp_d;
        end
    end
`endif

    assign period     = period_q;
    assign period_vld = vld_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receiving end of the divided-clock path: measures the period of a slow, asynchronous square wave (e.g. a divided slow_clk or an external tick) in cycles of the fast system clock.
- Synchronizes the input, detects rising edges, counts fast cycles between consecutive edges and publishes each result with a one-cycle valid strobe.
- Used for self-check of the clock-division chain and for display of measured rates on the ALU board.

Parameters:
- CNT_W, 24, width of the period counter and of the period output.
- TIMEOUT, 10000000, fast-clock cycles without a rising edge before measurement is declared lost; must be < 2^CNT_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sig_in  input  1  slow signal to measure; asynchronous to clk.
- meas_en  input  1  level enable; low forces IDLE.
- period  output  CNT_W  last measured period in clk cycles.
- period_vld  output  1  one-cycle pulse when period updates.
- timeout  output  1  level; set when TIMEOUT is reached with no edge.
- busy  output  1  high in ARM or MEASURE.

Behaviour:
- Reset (rst=0, async): sync flops=0, edge reg=0, cnt=0, period=0, period_vld=0, timeout=0, busy=0, state=IDLE.
- Input path: 2-flop synchronizer, then 1 history flop. A rising edge is detected when synced=1 and history=0. A sig_in rise meeting setup before clk edge k is detected at clk edge k+2.
- FSM states:
  - IDLE: cnt held at 0. Goes to ARM when meas_en=1.
  - ARM: waits for the first detected edge. On the edge, cnt<=1 and the state goes to MEASURE. No valid strobe.
  - MEASURE: cnt increments each non-edge cycle.
    - On a detected edge: period<=cnt, period_vld=1 for exactly one cycle, timeout<=0, cnt<=1, stay in MEASURE.
    - Result: edges detected at cycles t0 and t1 give period = t1-t0.
- Timeout: in ARM or MEASURE, when cnt (or a separate ARM wait counter, same width) reaches TIMEOUT, timeout<=1, cnt<=0, state goes to ARM, and period holds its old value. timeout stays set until the next valid measurement or until meas_en=0.
- meas_en=0 in any state: next cycle state=IDLE, cnt=0, timeout=0, no period_vld. period holds its last value.
- Simultaneous edge and cnt==TIMEOUT: the edge wins. Measurement is published and timeout is not set.
- Saturation: cnt never wraps. TIMEOUT < 2^CNT_W guarantees this; the counter additionally saturates at all-ones.
- Minimum measurable period is 2 cycles (sig_in high 1, low 1, synchronous). Input faster than clk/2 is undefined.
- busy = (state != IDLE), registered.
- Reset mid-operation: immediate return to reset values. First valid after release needs two edges.

Optional Feature:
- Macro: CLK_PERIOD_METER_AVG_EN.
- Defined:
  - period reports the mean of 4 consecutive measurements.
  - Accumulator width is CNT_W+2. period = sum>>2, truncated.
  - period_vld pulses once per 4 edge-to-edge measurements.
  - The accumulator and sample count clear on timeout, meas_en=0 and reset.
- Undefined: every measurement is published directly, as above.

Test Plan:
- Square wave with period 10 clk (5 high/5 low), meas_en=1 -> no vld on the first edge. From the second edge onward period=10, with period_vld pulsing exactly every 10 cycles, 3 cycles after each sig_in rise.
- TIMEOUT=100, sig_in held 0 after one edge -> timeout=1 at 100 cycles after the edge, state ARM, period unchanged, no vld. Resuming a period-20 wave -> first vld after two edges with period=20 and timeout=0.
- Period-2 wave (1 high/1 low) -> period=2 on every edge with vld every 2 cycles. Then period-7 asymmetric wave (2 high/5 low) -> period=7.
- meas_en dropped mid-MEASURE -> busy=0 the next cycle, no vld, period retains 10. Re-enable -> ARM, first result after two edges.
- rst pulsed low asynchronously mid-measurement -> all outputs 0 immediately, no stray vld after release.
- AVG_EN build: periods 10,10,12,12 -> a single vld with period=11. Periods 10,10,10,11 -> period=10 (truncation).
